// File: rtl/pipelined_cpu.sv
// Five-stage in-order RV32 subset CPU (IF/ID/EX/MEM/WB).
// Branches resolve in ID, operands forward into EX, and a load-use hazard costs one bubble.

package cpu_pkg;
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_XOR = 3'd3;
   localparam logic [2:0] ALU_SLL = 3'd4;
   localparam logic [2:0] ALU_MUL = 3'd5;
   localparam logic [2:0] ALU_SRA = 3'd6;
endpackage

module pipe_reg #(parameter int W = 32) (
   input  logic         clk_i,
   input  logic         i_rst_n,
   input  logic         i_en,
   input  logic         i_clr,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   always_ff @(posedge clk_i) begin
      if (!i_rst_n)   o_q <= '0;
      else if (i_clr) o_q <= '0;
      else if (i_en)  o_q <= i_d;
   end
endmodule

module pc_reg (
   input  logic        clk_i,
   input  logic        i_rst_n,
   input  logic        i_en,
   input  logic [31:0] i_next,
   output logic [31:0] pc_o
);
   always_ff @(posedge clk_i) begin
      if (!i_rst_n)  pc_o <= 32'd0;
      else if (i_en) pc_o <= i_next;
   end
endmodule

module imem (
   input  logic        clk_i,
   input  logic        i_we,
   input  logic [7:0]  i_waddr,
   input  logic [31:0] i_wdata,
   input  logic [7:0]  i_raddr,
   output logic [31:0] o_rdata
);
   logic [31:0] memory [0:255];
   always_ff @(posedge clk_i) begin
      if (i_we) memory[i_waddr] <= i_wdata;
   end
   assign o_rdata = memory[i_raddr];
endmodule

module regfile (
   input  logic        clk_i,
   input  logic        i_we,
   input  logic [4:0]  i_wa,
   input  logic [31:0] i_wd,
   input  logic [4:0]  i_ra1,
   input  logic [4:0]  i_ra2,
   output logic [31:0] o_rd1,
   output logic [31:0] o_rd2
);
   logic [31:0] register [0:31];
   always_ff @(posedge clk_i) begin
      if (i_we && i_wa != 5'd0) register[i_wa] <= i_wd;
   end
   // Write-through so an ID read three instructions behind a producer sees the new value
   assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : (i_we && i_wa == i_ra1) ? i_wd : register[i_ra1];
   assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : (i_we && i_wa == i_ra2) ? i_wd : register[i_ra2];
endmodule

module dmem (
   input  logic        clk_i,
   input  logic        i_we,
   input  logic [4:0]  i_addr,
   input  logic [31:0] i_wd,
   output logic [31:0] o_rd
);
   logic [7:0] memory [0:31];
   logic [4:0] w_a1, w_a2, w_a3;
   assign w_a1 = i_addr + 5'd1;
   assign w_a2 = i_addr + 5'd2;
   assign w_a3 = i_addr + 5'd3;
   always_ff @(posedge clk_i) begin
      if (i_we) begin
         memory[i_addr] <= i_wd[7:0];
         memory[w_a1]   <= i_wd[15:8];
         memory[w_a2]   <= i_wd[23:16];
         memory[w_a3]   <= i_wd[31:24];
      end
   end
   assign o_rd = {memory[w_a3], memory[w_a2], memory[w_a1], memory[i_addr]};
endmodule

module hazard_unit (
   input  logic       i_idex_mem_read,
   input  logic [4:0] i_idex_rd,
   input  logic [4:0] i_rs1,
   input  logic [4:0] i_rs2,
   output logic       stall_o
);
   assign stall_o = i_idex_mem_read && (i_idex_rd != 5'd0) &&
                    ((i_idex_rd == i_rs1) || (i_idex_rd == i_rs2));
endmodule

module control_unit
   import cpu_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic [6:0] i_funct7,
   input  logic       i_eq,
   input  logic       i_stall,
   output logic       o_reg_write,
   output logic       o_mem_read,
   output logic       o_mem_write,
   output logic       o_mem_to_reg,
   output logic       o_alu_src,
   output logic [2:0] o_alu_op,
   output logic       Branch_o,
   output logic       flush_o
);
   always_comb begin
      o_reg_write  = 1'b0;
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_mem_to_reg = 1'b0;
      o_alu_src    = 1'b0;
      o_alu_op     = ALU_ADD;
      Branch_o     = 1'b0;
      case (i_opcode)
         7'b0110011: begin
            o_reg_write = 1'b1;
            case ({i_funct7, i_funct3})
               10'b0000000_000: o_alu_op = ALU_ADD;
               10'b0100000_000: o_alu_op = ALU_SUB;
               10'b0000001_000: o_alu_op = ALU_MUL;
               10'b0000000_001: o_alu_op = ALU_SLL;
               10'b0000000_100: o_alu_op = ALU_XOR;
               10'b0000000_111: o_alu_op = ALU_AND;
               default:         o_reg_write = 1'b0;
            endcase
         end
         7'b0010011: begin
            o_alu_src = 1'b1;
            if (i_funct3 == 3'b000) begin
               o_reg_write = 1'b1;
            end else if (i_funct3 == 3'b101 && i_funct7 == 7'b0100000) begin
               o_reg_write = 1'b1;
               o_alu_op    = ALU_SRA;
            end else begin
               o_reg_write = 1'b0;
            end
         end
         7'b0000011: begin
            if (i_funct3 == 3'b010) begin
               o_reg_write  = 1'b1;
               o_mem_read   = 1'b1;
               o_mem_to_reg = 1'b1;
               o_alu_src    = 1'b1;
            end else begin
               o_reg_write  = 1'b0;
            end
         end
         7'b0100011: begin
            o_mem_write = (i_funct3 == 3'b010);
            o_alu_src   = 1'b1;
         end
         // A stalled beq is held in IF/ID and re-evaluated next cycle
         7'b1100011: Branch_o = (i_funct3 == 3'b000) && i_eq && !i_stall;
         default:    o_reg_write = 1'b0;
      endcase
   end
   assign flush_o = Branch_o;
endmodule

module pipelined_cpu
   import cpu_pkg::*;
(
   input logic clk_i,
   input logic start_i
);
   typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ifid_t;
   typedef struct packed {
      logic reg_write, mem_read, mem_write, mem_to_reg, alu_src;
      logic [2:0] alu_op;
      logic [31:0] rd1, rd2, imm;
      logic [4:0] rs1, rs2, rd;
   } idex_t;
   typedef struct packed {
      logic reg_write, mem_write, mem_to_reg;
      logic [31:0] alu, sdata;
      logic [4:0] rd;
   } exmem_t;
   typedef struct packed {
      logic reg_write, mem_to_reg;
      logic [31:0] alu, ldata;
      logic [4:0] rd;
   } memwb_t;

   logic [31:0] w_pc, w_pc_next, w_instr, w_rd1, w_rd2, w_imm, w_br_target;
   logic [31:0] w_fwd_a, w_fwd_b, w_alu_b, w_alu, w_ld_data, w_wb_data;
   logic [4:0]  w_rs1, w_rs2;
   logic [2:0]  w_alu_op;
   logic        w_stall, w_branch, w_flush;
   logic        w_reg_write, w_mem_read, w_mem_write, w_mem_to_reg, w_alu_src;
   ifid_t  w_ifid_d, r_ifid;
   idex_t  w_idex_d, r_idex;
   exmem_t w_exmem_d, r_exmem;
   memwb_t w_memwb_d, r_memwb;

   function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf,
                                       input exmem_t em, input memwb_t mw, input logic [31:0] wbd);
      if (em.reg_write && em.rd != 5'd0 && em.rd == rs)      return em.alu;
      else if (mw.reg_write && mw.rd != 5'd0 && mw.rd == rs) return wbd;
      else                                                   return rf;
   endfunction

   assign w_pc_next = w_branch ? w_br_target : w_pc + 32'd4;
   pc_reg PC (.clk_i, .i_rst_n(start_i), .i_en(!w_stall), .i_next(w_pc_next), .pc_o(w_pc));
   imem Instruction_Memory (.clk_i, .i_we(1'b0), .i_waddr(8'd0), .i_wdata(32'd0),
                            .i_raddr(w_pc[9:2]), .o_rdata(w_instr));

   assign w_ifid_d = '{pc: w_pc, instr: w_instr};
   pipe_reg #(.W($bits(ifid_t))) Pipe_IF_ID (.clk_i, .i_rst_n(start_i), .i_en(!w_stall),
                                            .i_clr(w_flush), .i_d(w_ifid_d), .o_q(r_ifid));

   assign w_rs1 = r_ifid.instr[19:15];
   assign w_rs2 = r_ifid.instr[24:20];
   regfile Registers (.clk_i, .i_we(r_memwb.reg_write), .i_wa(r_memwb.rd), .i_wd(w_wb_data),
                      .i_ra1(w_rs1), .i_ra2(w_rs2), .o_rd1(w_rd1), .o_rd2(w_rd2));
   hazard_unit Hazard_Detection_Unit (.i_idex_mem_read(r_idex.mem_read), .i_idex_rd(r_idex.rd),
                                      .i_rs1(w_rs1), .i_rs2(w_rs2), .stall_o(w_stall));
   control_unit Control (.i_opcode(r_ifid.instr[6:0]), .i_funct3(r_ifid.instr[14:12]),
                         .i_funct7(r_ifid.instr[31:25]), .i_eq(w_rd1 == w_rd2), .i_stall(w_stall),
                         .o_reg_write(w_reg_write), .o_mem_read(w_mem_read),
                         .o_mem_write(w_mem_write), .o_mem_to_reg(w_mem_to_reg),
                         .o_alu_src(w_alu_src), .o_alu_op(w_alu_op),
                         .Branch_o(w_branch), .flush_o(w_flush));

   assign w_imm = (r_ifid.instr[6:0] == 7'b0100011)
                ? {{20{r_ifid.instr[31]}}, r_ifid.instr[31:25], r_ifid.instr[11:7]}
                : {{20{r_ifid.instr[31]}}, r_ifid.instr[31:20]};
   assign w_br_target = r_ifid.pc + {{19{r_ifid.instr[31]}}, r_ifid.instr[31], r_ifid.instr[7],
                                     r_ifid.instr[30:25], r_ifid.instr[11:8], 1'b0};
   assign w_idex_d = '{reg_write: w_reg_write, mem_read: w_mem_read, mem_write: w_mem_write,
                       mem_to_reg: w_mem_to_reg, alu_src: w_alu_src, alu_op: w_alu_op,
                       rd1: w_rd1, rd2: w_rd2, imm: w_imm, rs1: w_rs1, rs2: w_rs2,
                       rd: r_ifid.instr[11:7]};
   pipe_reg #(.W($bits(idex_t))) Pipe_ID_EXE (.clk_i, .i_rst_n(start_i), .i_en(1'b1),
                                             .i_clr(w_stall), .i_d(w_idex_d), .o_q(r_idex));

   assign w_fwd_a = fwd(r_idex.rs1, r_idex.rd1, r_exmem, r_memwb, w_wb_data);
   assign w_fwd_b = fwd(r_idex.rs2, r_idex.rd2, r_exmem, r_memwb, w_wb_data);
   assign w_alu_b = r_idex.alu_src ? r_idex.imm : w_fwd_b;
   always_comb begin
      case (r_idex.alu_op)
         ALU_ADD: w_alu = w_fwd_a + w_alu_b;
         ALU_SUB: w_alu = w_fwd_a - w_alu_b;
         ALU_AND: w_alu = w_fwd_a & w_alu_b;
         ALU_XOR: w_alu = w_fwd_a ^ w_alu_b;
         ALU_SLL: w_alu = w_fwd_a << w_alu_b[4:0];
         ALU_MUL: w_alu = w_fwd_a * w_alu_b;
         ALU_SRA: w_alu = 32'($signed(w_fwd_a) >>> w_alu_b[4:0]);
         default: w_alu = 32'd0;
      endcase
   end
   assign w_exmem_d = '{reg_write: r_idex.reg_write, mem_write: r_idex.mem_write,
                        mem_to_reg: r_idex.mem_to_reg, alu: w_alu, sdata: w_fwd_b, rd: r_idex.rd};
   pipe_reg #(.W($bits(exmem_t))) Pipe_EX_MEM (.clk_i, .i_rst_n(start_i), .i_en(1'b1),
                                              .i_clr(1'b0), .i_d(w_exmem_d), .o_q(r_exmem));

   dmem Data_Memory (.clk_i, .i_we(r_exmem.mem_write), .i_addr(r_exmem.alu[4:0]),
                     .i_wd(r_exmem.sdata), .o_rd(w_ld_data));
   assign w_memwb_d = '{reg_write: r_exmem.reg_write, mem_to_reg: r_exmem.mem_to_reg,
                        alu: r_exmem.alu, ldata: w_ld_data, rd: r_exmem.rd};
   pipe_reg #(.W($bits(memwb_t))) Pipe_MEM_WB (.clk_i, .i_rst_n(start_i), .i_en(1'b1),
                                              .i_clr(1'b0), .i_d(w_memwb_d), .o_q(r_memwb));

   assign w_wb_data = r_memwb.mem_to_reg ? r_memwb.ldata : r_memwb.alu;
endmodule

// File: tb/tb_pipelined_cpu.sv
// Directed bench for pipelined_cpu: programs are preloaded through the hierarchy and
// expected register/memory contents are queued up front, then drained after each run.

module tb_pipelined_cpu;
   logic clk;
   logic start;
   int   errors = 0;
   int   checks = 0;
   int   stalls = 0;
   int   flushes = 0;

   typedef struct {
      string       tag;
      bit          is_mem;
      logic [4:0]  idx;
      logic [31:0] exp;
   } sb_item_t;
   sb_item_t sb[$];

   pipelined_cpu dut (.clk_i(clk), .start_i(start));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
      return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
      return i_type(imm, rs1, 3'b000, rd, 7'b0010011);
   endfunction
   function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [11:0] imm);
      return i_type(imm, rs1, 3'b010, rd, 7'b0000011);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_reg(input string tag, input logic [4:0] r, input logic [31:0] v);
      sb.push_back('{tag: tag, is_mem: 1'b0, idx: r, exp: v});
   endtask
   task automatic expect_mem(input string tag, input logic [4:0] a, input logic [7:0] v);
      sb.push_back('{tag: tag, is_mem: 1'b1, idx: a, exp: {24'd0, v}});
   endtask

   task automatic drain();
      sb_item_t    it;
      logic [31:0] obs;
      while (sb.size() != 0) begin
         it = sb.pop_front();
         if (it.is_mem) obs = {24'd0, dut.Data_Memory.memory[it.idx]};
         else           obs = dut.Registers.register[it.idx];
         check(it.tag, obs, it.exp);
      end
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] <= 32'd0;
   endtask

   // Holds the core in reset for one cycle, then leaves the caller at a negedge to preload.
   task automatic begin_test();
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      stalls  = 0;
      flushes = 0;
      clear_imem();
   endtask

   task automatic run(input int n);
      start = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (dut.Hazard_Detection_Unit.stall_o === 1'b1) stalls++;
         if (dut.Control.flush_o === 1'b1) flushes++;
      end
   endtask

   logic signed [31:0] g5, g6, g7, g8, g9, g10, g11;

   initial begin
      start = 1'b0;
      // Test 1: reset behaviour
      clear_imem();
      dut.Instruction_Memory.memory[0] <= addi(5'd20, 5'd0, 12'd1);
      dut.Instruction_Memory.memory[1] <= s_type(12'd31, 5'd20, 5'd0);
      dut.Registers.register[20] <= 32'hA5A5_5A5A;
      dut.Data_Memory.memory[31] <= 8'h3C;
      @(posedge clk); @(negedge clk);
      check("t1_pc_rst0", dut.PC.pc_o, 32'd0);
      @(posedge clk); @(negedge clk);
      check("t1_pc_rst1", dut.PC.pc_o, 32'd0);
      check("t1_reg_hold", dut.Registers.register[20], 32'hA5A5_5A5A);
      check("t1_mem_hold", {24'd0, dut.Data_Memory.memory[31]}, 32'h0000_003C);
      start = 1'b1;
      @(posedge clk); @(negedge clk);
      check("t1_pc_4", dut.PC.pc_o, 32'd4);
      @(posedge clk); @(negedge clk);
      check("t1_pc_8", dut.PC.pc_o, 32'd8);

      // Test 2: back-to-back ALU forwarding
      begin_test();
      dut.Instruction_Memory.memory[0] <= addi(5'd1, 5'd0, 12'd5);
      dut.Instruction_Memory.memory[1] <= addi(5'd2, 5'd0, 12'd3);
      dut.Instruction_Memory.memory[2] <= r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
      dut.Registers.register[3] <= 32'd0;
      expect_reg("t2_x3", 5'd3, 32'd8);
      run(10);
      check("t2_no_stall", stalls, 32'd0);
      drain();

      // Test 3: load-use stall
      begin_test();
      dut.Data_Memory.memory[0] <= 8'd5;
      dut.Data_Memory.memory[1] <= 8'd0;
      dut.Data_Memory.memory[2] <= 8'd0;
      dut.Data_Memory.memory[3] <= 8'd0;
      dut.Registers.register[2] <= 32'd0;
      dut.Instruction_Memory.memory[0] <= lw(5'd1, 5'd0, 12'd0);
      dut.Instruction_Memory.memory[1] <= r_type(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2);
      expect_reg("t3_x2", 5'd2, 32'd10);
      run(10);
      check("t3_one_stall", stalls, 32'd1);
      check("t3_pc_held", dut.PC.pc_o, 32'd36);
      drain();

      // Test 4: taken branch flushes the fall-through instruction
      begin_test();
      dut.Registers.register[1] <= 32'd1;
      dut.Registers.register[4] <= 32'd0;
      dut.Registers.register[5] <= 32'd0;
      dut.Instruction_Memory.memory[0] <= b_type(13'd8, 5'd1, 5'd1);
      dut.Instruction_Memory.memory[1] <= addi(5'd4, 5'd0, 12'd9);
      dut.Instruction_Memory.memory[2] <= addi(5'd5, 5'd0, 12'd7);
      expect_reg("t4_x4", 5'd4, 32'd0);
      expect_reg("t4_x5", 5'd5, 32'd7);
      run(10);
      check("t4_one_flush", flushes, 32'd1);
      drain();

      // Test 5: store then load of the same word
      begin_test();
      dut.Registers.register[3] <= 32'h1234_5678;
      dut.Registers.register[6] <= 32'd0;
      for (int i = 4; i < 8; i++) dut.Data_Memory.memory[i] <= 8'd0;
      dut.Instruction_Memory.memory[0] <= s_type(12'd4, 5'd3, 5'd0);
      dut.Instruction_Memory.memory[1] <= lw(5'd6, 5'd0, 12'd4);
      expect_mem("t5_m4", 5'd4, 8'h78);
      expect_mem("t5_m5", 5'd5, 8'h56);
      expect_mem("t5_m6", 5'd6, 8'h34);
      expect_mem("t5_m7", 5'd7, 8'h12);
      expect_reg("t5_x6", 5'd6, 32'h1234_5678);
      run(10);
      drain();

      // Test 6: ALU mix against a bench-side golden model
      begin_test();
      dut.Registers.register[0]  <= 32'd0;
      dut.Registers.register[1]  <= 32'd8;
      dut.Registers.register[2]  <= 32'd3;
      dut.Registers.register[12] <= 32'h0000_0021;
      dut.Registers.register[31] <= 32'hDEAD_BEEF;
      for (int i = 5; i < 12; i++) dut.Registers.register[i] <= 32'd0;
      dut.Registers.register[13] <= 32'd0;
      dut.Instruction_Memory.memory[0] <= r_type(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd5);
      dut.Instruction_Memory.memory[1] <= i_type({7'b0100000, 5'd1}, 5'd5, 3'b101, 5'd6, 7'b0010011);
      dut.Instruction_Memory.memory[2] <= r_type(7'b0000001, 5'd6, 5'd2, 3'b000, 5'd7);
      dut.Instruction_Memory.memory[3] <= r_type(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd8);
      dut.Instruction_Memory.memory[4] <= r_type(7'b0000000, 5'd8, 5'd1, 3'b111, 5'd9);
      dut.Instruction_Memory.memory[5] <= r_type(7'b0000000, 5'd2, 5'd2, 3'b001, 5'd10);
      dut.Instruction_Memory.memory[6] <= r_type(7'b0000000, 5'd12, 5'd2, 3'b001, 5'd11);
      dut.Instruction_Memory.memory[7] <= addi(5'd0, 5'd0, 12'd5);
      dut.Instruction_Memory.memory[8] <= r_type(7'b0000000, 5'd1, 5'd0, 3'b000, 5'd13);
      dut.Instruction_Memory.memory[9] <= 32'hFFFF_FFFF;
      g5  = 32'sd0 - 32'sd8;
      g6  = g5 >>> 1;
      g7  = 32'sd3 * g6;
      g8  = 32'sd8 ^ 32'sd3;
      g9  = 32'sd8 & g8;
      g10 = 32'sd3 << 3;
      g11 = 32'sd3 << (32'h21 & 32'h1F);
      expect_reg("t6_sub", 5'd5, g5);
      expect_reg("t6_srai", 5'd6, g6);
      expect_reg("t6_mul", 5'd7, g7);
      expect_reg("t6_xor", 5'd8, g8);
      expect_reg("t6_and", 5'd9, g9);
      expect_reg("t6_sll", 5'd10, g10);
      expect_reg("t6_sll_mask", 5'd11, g11);
      expect_reg("t6_x0", 5'd0, 32'd0);
      expect_reg("t6_x0_nofwd", 5'd13, 32'd8);
      expect_reg("t6_unknown_op", 5'd31, 32'hDEAD_BEEF);
      run(18);
      check("t6_no_stall", stalls, 32'd0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
